// File: rtl/irq_prio_ctrl_if.sv
// Source-to-sink interrupt request channel: a held request with a vector, a priority and a
// snapshot of the pending sources, plus the sink's acknowledge and the source's error flag.
interface irq_prio_ctrl_if #(
    parameter int N      = 32,
    parameter int PRIO_W = 0
);
    localparam int VEC_W = (N <= 1) ? 1 : $clog2(N);
    localparam int PW    = (PRIO_W == 0) ? 1 : PRIO_W;

    logic             irq_valid;
    logic [VEC_W-1:0] irq_vector;
    logic [PW-1:0]    irq_prio;
    logic [N-1:0]     irq_pending;
    logic             irq_ack;
    logic [VEC_W-1:0] irq_ack_vector;
    logic             ack_err;

    modport master (
        output irq_valid, irq_vector, irq_prio, irq_pending, ack_err,
        input  irq_ack, irq_ack_vector
    );

    modport slave (
        input  irq_valid, irq_vector, irq_prio, irq_pending, ack_err,
        output irq_ack, irq_ack_vector
    );
endinterface

// File: rtl/irq_prio_ctrl.sv
// Prioritised interrupt source: latches edge events, arbitrates enabled requests and holds the winner
// until acked. A level request shows one edge after it is sampled, an edge request two; a stalled sink freezes all outputs.
module irq_prio_ctrl #(
    parameter int  N      = 32,
    parameter int  PRIO_W = 0,
    localparam int VEC_W  = (N <= 1) ? 1 : $clog2(N),
    localparam int PW     = (PRIO_W == 0) ? 1 : PRIO_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     irq_src,
    input  logic             cfg_we,
    input  logic [VEC_W-1:0] cfg_idx,
    input  logic             cfg_en,
    input  logic             cfg_edge,
    input  logic [PW-1:0]    cfg_prio,
    irq_prio_ctrl_if.master  irq
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     en_q, edge_sel_q, src_q, edge_pend_q, edge_pend_d;
    logic [PW-1:0]    prio_q   [N];
    logic [PW-1:0]    prio_eff [N];
    logic [N-1:0]     pending, elig, set_mask, clr_mask;
    logic             cfg_wr_ok;
    logic             win_found;
    logic [VEC_W-1:0] win_vec;
    logic [PW-1:0]    win_prio;
    logic [VEC_W-1:0] vector_q;
    logic [PW-1:0]    prio_out_q;
    logic [N-1:0]     pend_out_q;
    logic             ack_err_q;
    logic             load, ack_ok, bad_ack;

    assign cfg_wr_ok = cfg_we && (int'(cfg_idx) < N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= '0;
            edge_sel_q <= '0;
            for (int i = 0; i < N; i++) prio_q[i] <= '0;
        end else if (cfg_wr_ok) begin
            en_q[cfg_idx]       <= cfg_en;
            edge_sel_q[cfg_idx] <= cfg_edge;
            prio_q[cfg_idx]     <= cfg_prio;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) prio_eff[i] = (PRIO_W == 0) ? '0 : prio_q[i];
    end

    // A fresh edge overrides a same-cycle clear so the new event is never lost.
    assign set_mask = edge_sel_q & irq_src & ~src_q;

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < N; i++)
            clr_mask[i] = ack_ok && edge_sel_q[i] && (vector_q == VEC_W'(i));
    end

    assign edge_pend_d = (edge_pend_q & ~clr_mask) | set_mask;
    assign pending     = (edge_sel_q & edge_pend_q) | (~edge_sel_q & irq_src);
    assign elig        = pending & en_q;

    // Strict greater-than keeps the lowest index on a priority tie.
    always_comb begin
        win_found = 1'b0;
        win_vec   = '0;
        win_prio  = '0;
        for (int i = 0; i < N; i++) begin
            if (elig[i] && (!win_found || prio_eff[i] > win_prio)) begin
                win_found = 1'b1;
                win_vec   = VEC_W'(i);
                win_prio  = prio_eff[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ack_ok  = 1'b0;
        bad_ack = 1'b0;
        case (state_q)
            IDLE: begin
                bad_ack = irq.irq_ack;
                if (win_found) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (irq.irq_ack) begin
                    if (irq.irq_ack_vector == vector_q) begin
                        ack_ok  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bad_ack = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q       <= '0;
            edge_pend_q <= '0;
            vector_q    <= '0;
            prio_out_q  <= '0;
            pend_out_q  <= '0;
            ack_err_q   <= 1'b0;
        end else begin
            src_q       <= irq_src;
            edge_pend_q <= edge_pend_d;
            ack_err_q   <= bad_ack;
            if (load) begin
                vector_q   <= win_vec;
                prio_out_q <= win_prio;
                pend_out_q <= elig;
            end
        end
    end

    assign irq.irq_valid   = (state_q == PRESENT);
    assign irq.irq_vector  = vector_q;
    assign irq.irq_prio    = prio_out_q;
    assign irq.irq_pending = pend_out_q;
    assign irq.ack_err     = ack_err_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Bench for irq_prio_ctrl (N=8, PRIO_W=2): expected requests are queued as stimulus is driven and
// popped as the DUT presents them; the sink is either combinational (ack = valid) or hand-driven.
module tb_irq_prio_ctrl;

    typedef struct packed {
        logic [2:0] vec;
        logic [1:0] prio;
        logic [7:0] pend;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_src;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic       cfg_en;
    logic       cfg_edge;
    logic [1:0] cfg_prio;
    logic       auto_ack;
    logic       man_ack;
    logic [2:0] man_vec;

    int   checks = 0;
    int   passes = 0;
    exp_t exp_q[$];

    irq_prio_ctrl_if #(.N(8), .PRIO_W(2)) ifc ();

    assign ifc.irq_ack        = auto_ack ? ifc.irq_valid  : man_ack;
    assign ifc.irq_ack_vector = auto_ack ? ifc.irq_vector : man_vec;

    irq_prio_ctrl #(.N(8), .PRIO_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_src  (irq_src),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_en   (cfg_en),
        .cfg_edge (cfg_edge),
        .cfg_prio (cfg_prio),
        .irq      (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cfg(input int idx, input bit en, input bit edge_mode, input int prio);
        cfg_we   = 1'b1;
        cfg_idx  = 3'(idx);
        cfg_en   = en;
        cfg_edge = edge_mode;
        cfg_prio = 2'(prio);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok, output int waited);
        waited = 0;
        while (ifc.irq_valid !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        ok = (ifc.irq_valid === 1'b1);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        irq_src  = '0;
        cfg_we   = 1'b0;
        cfg_idx  = '0;
        cfg_en   = 1'b0;
        cfg_edge = 1'b0;
        cfg_prio = '0;
        auto_ack = 1'b1;
        man_ack  = 1'b0;
        man_vec  = '0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        @(negedge clk);
        irq_src = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (ifc.irq_valid !== 1'b0) $display("FAIL reset_valid cycle %0d: got %b want 0", i, ifc.irq_valid);
            else passes++;
        end
        checks++;
        if ({ifc.irq_vector, ifc.irq_prio, ifc.irq_pending, ifc.ack_err} !== 14'h0)
            $display("FAIL reset_outputs: got vec=%0d prio=%0d pend=%b err=%b want all 0",
                     ifc.irq_vector, ifc.irq_prio, ifc.irq_pending, ifc.ack_err);
        else passes++;
        irq_src = '0;
        @(negedge clk);
    endtask

    task automatic test_edge_priority();
        bit   ok;
        int   waited;
        exp_t e;
        exp_t got;
        cfg(0, 1, 1, 1);
        cfg(2, 1, 1, 1);
        cfg(4, 1, 1, 0);
        exp_q.push_back('{vec: 3'd0, prio: 2'd1, pend: 8'b0001_0101});
        exp_q.push_back('{vec: 3'd2, prio: 2'd1, pend: 8'b0001_0100});
        exp_q.push_back('{vec: 3'd4, prio: 2'd0, pend: 8'b0001_0000});
        irq_src = 8'b0001_0101;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) irq_src = '0;
            wait_valid(10, ok, waited);
            checks++;
            if (!ok || waited != 1) $display("FAIL edge_timing #%0d: got valid=%b after %0d cycles want valid=1 after 1", i, ok, waited);
            else passes++;
            e   = exp_q.pop_front();
            got = {ifc.irq_vector, ifc.irq_prio, ifc.irq_pending};
            checks++;
            if (got !== e) $display("FAIL edge_order #%0d: got vec=%0d prio=%0d pend=%b want vec=%0d prio=%0d pend=%b",
                                    i, got.vec, got.prio, got.pend, e.vec, e.prio, e.pend);
            else passes++;
        end
        @(negedge clk);
        wait_valid(20, ok, waited);
        checks++;
        if (ok) $display("FAIL edge_drained: got valid=1 vec=%0d want valid=0", ifc.irq_vector);
        else passes++;
    endtask

    task automatic test_level();
        bit   ok;
        int   waited;
        exp_t e;
        exp_t got;
        cfg(5, 1, 0, 2);
        cfg(7, 1, 0, 2);
        for (int i = 0; i < 3; i++) exp_q.push_back('{vec: 3'd5, prio: 2'd2, pend: 8'b1010_0000});
        irq_src = 8'b1010_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wait_valid(10, ok, waited);
            checks++;
            if (!ok || waited != (i == 0 ? 0 : 1))
                $display("FAIL level_timing #%0d: got valid=%b after %0d cycles want valid=1 after %0d", i, ok, waited, (i == 0 ? 0 : 1));
            else passes++;
            e   = exp_q.pop_front();
            got = {ifc.irq_vector, ifc.irq_prio, ifc.irq_pending};
            checks++;
            if (got !== e) $display("FAIL level_repeat #%0d: got vec=%0d prio=%0d pend=%b want vec=%0d prio=%0d pend=%b",
                                    i, got.vec, got.prio, got.pend, e.vec, e.prio, e.pend);
            else passes++;
        end
        irq_src = 8'b1000_0000;
        exp_q.push_back('{vec: 3'd7, prio: 2'd2, pend: 8'b1000_0000});
        @(negedge clk);
        wait_valid(10, ok, waited);
        checks++;
        if (!ok || waited != 1) $display("FAIL level_drop_timing: got valid=%b after %0d cycles want valid=1 after 1", ok, waited);
        else passes++;
        e   = exp_q.pop_front();
        got = {ifc.irq_vector, ifc.irq_prio, ifc.irq_pending};
        checks++;
        if (got !== e) $display("FAIL level_drop: got vec=%0d prio=%0d pend=%b want vec=%0d prio=%0d pend=%b",
                                got.vec, got.prio, got.pend, e.vec, e.prio, e.pend);
        else passes++;
        irq_src = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall();
        bit   ok;
        int   waited;
        exp_t e;
        exp_t got;
        auto_ack = 1'b0;
        man_ack  = 1'b0;
        cfg(3, 1, 1, 1);
        exp_q.push_back('{vec: 3'd3, prio: 2'd1, pend: 8'b0000_1000});
        irq_src = 8'b0000_1000;
        @(negedge clk);
        irq_src = '0;
        wait_valid(10, ok, waited);
        checks++;
        if (!ok) $display("FAIL stall_present: got valid=0 want 1");
        else passes++;
        e = exp_q.pop_front();
        cfg(3, 0, 1, 1);
        cfg(6, 1, 1, 3);
        irq_src = 8'b0100_0000;
        @(negedge clk);
        irq_src = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got = {ifc.irq_vector, ifc.irq_prio, ifc.irq_pending};
            checks++;
            if (ifc.irq_valid !== 1'b1 || got !== e)
                $display("FAIL stall_hold cycle %0d: got valid=%b vec=%0d prio=%0d pend=%b want valid=1 vec=%0d prio=%0d pend=%b",
                         i, ifc.irq_valid, got.vec, got.prio, got.pend, e.vec, e.prio, e.pend);
            else passes++;
        end
        man_ack = 1'b1;
        man_vec = 3'd3;
        exp_q.push_back('{vec: 3'd6, prio: 2'd3, pend: 8'b0100_0000});
        @(negedge clk);
        man_ack = 1'b0;
        checks++;
        if (ifc.irq_valid !== 1'b0) $display("FAIL stall_release: got valid=%b want 0", ifc.irq_valid);
        else passes++;
        wait_valid(10, ok, waited);
        checks++;
        if (!ok || waited != 1) $display("FAIL stall_next_timing: got valid=%b after %0d cycles want valid=1 after 1", ok, waited);
        else passes++;
        e   = exp_q.pop_front();
        got = {ifc.irq_vector, ifc.irq_prio, ifc.irq_pending};
        checks++;
        if (got !== e) $display("FAIL stall_next: got vec=%0d prio=%0d pend=%b want vec=%0d prio=%0d pend=%b",
                                got.vec, got.prio, got.pend, e.vec, e.prio, e.pend);
        else passes++;
        auto_ack = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bad_ack();
        bit   ok;
        int   waited;
        exp_t e;
        exp_t got;
        auto_ack = 1'b0;
        exp_q.push_back('{vec: 3'd2, prio: 2'd1, pend: 8'b0000_0100});
        irq_src = 8'b0000_0100;
        @(negedge clk);
        irq_src = '0;
        wait_valid(10, ok, waited);
        e   = exp_q.pop_front();
        got = {ifc.irq_vector, ifc.irq_prio, ifc.irq_pending};
        checks++;
        if (!ok || got !== e) $display("FAIL bad_ack_setup: got valid=%b vec=%0d pend=%b want valid=1 vec=%0d pend=%b",
                                       ok, got.vec, got.pend, e.vec, e.pend);
        else passes++;
        man_ack = 1'b1;
        man_vec = 3'd1;
        @(negedge clk);
        man_ack = 1'b0;
        checks++;
        if ({ifc.ack_err, ifc.irq_valid, ifc.irq_vector} !== {1'b1, 1'b1, 3'd2})
            $display("FAIL bad_ack_err: got err=%b valid=%b vec=%0d want err=1 valid=1 vec=2", ifc.ack_err, ifc.irq_valid, ifc.irq_vector);
        else passes++;
        @(negedge clk);
        checks++;
        if ({ifc.ack_err, ifc.irq_valid} !== 2'b01)
            $display("FAIL bad_ack_pulse: got err=%b valid=%b want err=0 valid=1", ifc.ack_err, ifc.irq_valid);
        else passes++;
        man_ack = 1'b1;
        man_vec = 3'd2;
        @(negedge clk);
        man_ack = 1'b0;
        checks++;
        if ({ifc.ack_err, ifc.irq_valid} !== 2'b00)
            $display("FAIL good_ack: got err=%b valid=%b want err=0 valid=0", ifc.ack_err, ifc.irq_valid);
        else passes++;
        wait_valid(10, ok, waited);
        checks++;
        if (ok) $display("FAIL good_ack_cleared: got valid=1 vec=%0d want valid=0", ifc.irq_vector);
        else passes++;
        man_ack = 1'b1;
        man_vec = 3'd0;
        @(negedge clk);
        man_ack = 1'b0;
        checks++;
        if ({ifc.ack_err, ifc.irq_valid} !== 2'b10)
            $display("FAIL stray_ack: got err=%b valid=%b want err=1 valid=0", ifc.ack_err, ifc.irq_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if ({ifc.ack_err, ifc.irq_valid} !== 2'b00)
            $display("FAIL stray_ack_pulse: got err=%b valid=%b want err=0 valid=0", ifc.ack_err, ifc.irq_valid);
        else passes++;
    endtask

    task automatic test_collision();
        bit   ok;
        int   waited;
        exp_t e;
        exp_t got;
        auto_ack = 1'b1;
        exp_q.push_back('{vec: 3'd2, prio: 2'd1, pend: 8'b0000_0100});
        exp_q.push_back('{vec: 3'd2, prio: 2'd1, pend: 8'b0000_0100});
        irq_src = 8'b0000_0100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            irq_src = '0;
            wait_valid(10, ok, waited);
            checks++;
            if (!ok || waited != 1) $display("FAIL collision_timing #%0d: got valid=%b after %0d cycles want valid=1 after 1", i, ok, waited);
            else passes++;
            e   = exp_q.pop_front();
            got = {ifc.irq_vector, ifc.irq_prio, ifc.irq_pending};
            checks++;
            if (got !== e) $display("FAIL collision #%0d: got vec=%0d prio=%0d pend=%b want vec=%0d prio=%0d pend=%b",
                                    i, got.vec, got.prio, got.pend, e.vec, e.prio, e.pend);
            else passes++;
            // Re-raise source 2 on the cycle its acknowledge lands.
            if (i == 0) irq_src = 8'b0000_0100;
        end
        @(negedge clk);
        wait_valid(8, ok, waited);
        checks++;
        if (ok) $display("FAIL collision_drained: got valid=1 vec=%0d want valid=0", ifc.irq_vector);
        else passes++;
    endtask

    task automatic test_mid_reset();
        bit   ok;
        int   waited;
        exp_t e;
        exp_t got;
        auto_ack = 1'b0;
        exp_q.push_back('{vec: 3'd0, prio: 2'd1, pend: 8'b0001_0001});
        irq_src = 8'b0001_0001;
        @(negedge clk);
        irq_src = '0;
        wait_valid(10, ok, waited);
        e   = exp_q.pop_front();
        got = {ifc.irq_vector, ifc.irq_prio, ifc.irq_pending};
        checks++;
        if (!ok || got !== e) $display("FAIL reset_setup: got valid=%b vec=%0d prio=%0d pend=%b want valid=1 vec=%0d prio=%0d pend=%b",
                                       ok, got.vec, got.prio, got.pend, e.vec, e.prio, e.pend);
        else passes++;
        man_ack = 1'b1;
        man_vec = 3'd5;
        @(negedge clk);
        man_ack = 1'b0;
        checks++;
        if ({ifc.ack_err, ifc.irq_valid} !== 2'b11) $display("FAIL reset_pre_err: got err=%b valid=%b want err=1 valid=1", ifc.ack_err, ifc.irq_valid);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ifc.irq_valid, ifc.irq_vector, ifc.irq_prio, ifc.irq_pending, ifc.ack_err} !== 15'h0)
            $display("FAIL reset_async: got valid=%b vec=%0d prio=%0d pend=%b err=%b want all 0",
                     ifc.irq_valid, ifc.irq_vector, ifc.irq_prio, ifc.irq_pending, ifc.ack_err);
        else passes++;
        @(negedge clk);
        rst_n    = 1'b1;
        auto_ack = 1'b1;
        cfg(0, 1, 1, 1);
        cfg(4, 1, 1, 0);
        wait_valid(20, ok, waited);
        checks++;
        if (ok) $display("FAIL reset_events_lost: got valid=1 vec=%0d want valid=0", ifc.irq_vector);
        else passes++;
        exp_q.push_back('{vec: 3'd4, prio: 2'd0, pend: 8'b0001_0000});
        irq_src = 8'b0001_0000;
        @(negedge clk);
        irq_src = '0;
        wait_valid(10, ok, waited);
        checks++;
        if (!ok || waited != 1) $display("FAIL reset_new_edge_timing: got valid=%b after %0d cycles want valid=1 after 1", ok, waited);
        else passes++;
        e   = exp_q.pop_front();
        got = {ifc.irq_vector, ifc.irq_prio, ifc.irq_pending};
        checks++;
        if (got !== e) $display("FAIL reset_new_edge: got vec=%0d prio=%0d pend=%b want vec=%0d prio=%0d pend=%b",
                                got.vec, got.prio, got.pend, e.vec, e.prio, e.pend);
        else passes++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_edge_priority();
        test_level();
        test_stall();
        test_bad_ack();
        test_collision();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d entries left want 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
